wb_regfile: RTL and testbench

- Writeback stage of the five-stage pipeline, directly downstream of the MEM/WB pipeline register.
- Selects the writeback value from the MEM/WB outputs (ALU result, data-memory word, PC+4, negative flag) using the 2-bit memtoreg code.
- Commits the selected value into a 32x32 general-purpose register file and serves the two ID-stage read ports.
- Read ports bypass same-cycle writes, so ID never reads a stale operand during a WB write.

---
 rtl/wb_regfile_pkg.sv | 17 +
 rtl/wb_regfile_if.sv | 33 +++
 rtl/wb_regfile_2r1w.sv | 57 +++++
 rtl/wb_regfile.sv | 53 +++++
 tb/tb_wb_regfile.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the writeback stage: writeback-select
// encodings and register-address constants.
package wb_regfile_pkg;

    // Writeback-select codes driven by the MEM/WB register
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC  = 2'b10,
        WB_NEG = 2'b11
    } wb_sel_e;

    // Register-number width and the hard-wired zero register
    localparam int unsigned           REG_AW   = 5;
    localparam logic [REG_AW-1:0]     REG_ZERO = '0;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback/register-file bus: MEM/WB inputs, ID-stage read ports and the
// forwarding outputs. The pipeline side uses master, the stage uses slave.
interface wb_regfile_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
);
    import wb_regfile_pkg::*;

    logic [1:0]        memtoreg;
    logic              regwr;
    logic [REG_AW-1:0] regdst;
    logic [DWIDTH-1:0] aluout;
    logic [DWIDTH-1:0] dmdata;
    logic [AWIDTH-1:0] pcnext;
    logic              negative;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [DWIDTH-1:0] rsdata;
    logic [DWIDTH-1:0] rtdata;
    logic [DWIDTH-1:0] wbdata;
    logic              wbvalid;

    modport master (
        output memtoreg, regwr, regdst, aluout, dmdata, pcnext, negative, rs, rt,
        input  rsdata, rtdata, wbdata, wbvalid
    );

    modport slave (
        input  memtoreg, regwr, regdst, aluout, dmdata, pcnext, negative, rs, rt,
        output rsdata, rtdata, wbdata, wbvalid
    );

endinterface

// File: rtl/wb_regfile_2r1w.sv
// Two-read/one-write register file with asynchronous clear, hard-wired r0
// and write-through bypass on both read ports.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DWIDTH-1:0] wd,
    input  logic [REG_AW-1:0] ra_a,
    input  logic [REG_AW-1:0] ra_b,
    output logic [DWIDTH-1:0] rd_a,
    output logic [DWIDTH-1:0] rd_b,
    output logic              wvalid
);

    logic [DWIDTH-1:0] regs [NREGS];

    // A write only counts when it targets a real (non-zero) register
    assign wvalid = we && (wa != REG_ZERO);

    // Register array: asynchronous clear, single write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wvalid) begin
            regs[wa] <= wd;
        end
    end

    // Port A read: r0 forced to zero, same-cycle write bypassed
    always_comb begin
        rd_a = regs[ra_a];
        if (wvalid && (ra_a == wa)) begin
            rd_a = wd;
        end
        if (ra_a == REG_ZERO) begin
            rd_a = '0;
        end
    end

    // Port B read: identical to port A
    always_comb begin
        rd_b = regs[ra_b];
        if (wvalid && (ra_b == wa)) begin
            rd_b = wd;
        end
        if (ra_b == REG_ZERO) begin
            rd_b = '0;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value from the MEM/WB outputs and
// commits it into the general-purpose register file.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);

    logic [DWIDTH-1:0] wbsel;
    logic [DWIDTH-1:0] rd_a;
    logic [DWIDTH-1:0] rd_b;
    logic              wvalid;

    // Writeback mux; an unknown select propagates as X
    always_comb begin
        wbsel = 'x;
        case (bus.memtoreg)
            WB_ALU:  wbsel = bus.aluout;
            WB_MEM:  wbsel = bus.dmdata;
            WB_PC:   wbsel = DWIDTH'(bus.pcnext);
            WB_NEG:  wbsel = DWIDTH'(bus.negative);
            default: wbsel = 'x;
        endcase
    end

    regfile_2r1w #(
        .DWIDTH (DWIDTH),
        .NREGS  (NREGS)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.regwr),
        .wa     (bus.regdst),
        .wd     (wbsel),
        .ra_a   (bus.rs),
        .ra_b   (bus.rt),
        .rd_a   (rd_a),
        .rd_b   (rd_b),
        .wvalid (wvalid)
    );

    assign bus.wbdata  = wbsel;
    assign bus.wbvalid = wvalid;
    assign bus.rsdata  = rd_a;
    assign bus.rtdata  = rd_b;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for the writeback stage and register file.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    wb_regfile_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

    wb_regfile #(.DWIDTH(32), .AWIDTH(32), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write one register through the ALU path, leaving regwr low afterwards
    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        @(negedge clk);
        bus.regwr    = 1'b1;
        bus.regdst   = r;
        bus.memtoreg = WB_ALU;
        bus.aluout   = v;
        @(posedge clk);
        #1;
        bus.regwr = 1'b0;
    endtask

    task automatic test_reset_init;
        bus.rs = 5'd1;
        bus.rt = 5'd31;
        #1;
        total++; if (bus.rsdata !== 32'h0) begin bad++; $display("FAIL init_rs got=%h exp=%h", bus.rsdata, 32'h0); end
        total++; if (bus.rtdata !== 32'h0) begin bad++; $display("FAIL init_rt got=%h exp=%h", bus.rtdata, 32'h0); end
        total++; if (bus.wbvalid !== 1'b0) begin bad++; $display("FAIL init_wbvalid got=%b exp=0", bus.wbvalid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000_0000 | 32'(i));
        bus.rs = 5'd10;
        bus.rt = 5'd31;
        #1;
        total++; if (bus.rsdata !== 32'h1000_000A) begin bad++; $display("FAIL preload_r10 got=%h exp=%h", bus.rsdata, 32'h1000_000A); end
        total++; if (bus.rtdata !== 32'h1000_001F) begin bad++; $display("FAIL preload_r31 got=%h exp=%h", bus.rtdata, 32'h1000_001F); end
        // Assert reset mid-cycle; contents must clear before the next edge
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (bus.rsdata !== 32'h0) begin bad++; $display("FAIL async_clr_r10 got=%h exp=%h", bus.rsdata, 32'h0); end
        total++; if (bus.rtdata !== 32'h0) begin bad++; $display("FAIL async_clr_r31 got=%h exp=%h", bus.rtdata, 32'h0); end
        for (int i = 1; i < 32; i++) begin
            bus.rs = 5'(i);
            bus.rt = 5'(32 - i);
            #1;
            total++; if (bus.rsdata !== 32'h0) begin bad++; $display("FAIL clr_rs r%0d got=%h exp=%h", i, bus.rsdata, 32'h0); end
            total++; if (bus.rtdata !== 32'h0) begin bad++; $display("FAIL clr_rt r%0d got=%h exp=%h", 32 - i, bus.rtdata, 32'h0); end
        end
        // Write attempted while reset is held
        @(negedge clk);
        bus.regwr    = 1'b1;
        bus.regdst   = 5'd5;
        bus.memtoreg = WB_ALU;
        bus.aluout   = 32'h5555_5555;
        bus.rs       = 5'd5;
        bus.rt       = 5'd6;
        #1;
        total++; if (bus.rsdata !== 32'h5555_5555) begin bad++; $display("FAIL rst_bypass got=%h exp=%h", bus.rsdata, 32'h5555_5555); end
        total++; if (bus.rtdata !== 32'h0) begin bad++; $display("FAIL rst_other got=%h exp=%h", bus.rtdata, 32'h0); end
        @(posedge clk);
        #1;
        bus.regwr = 1'b0;
        #1;
        total++; if (bus.rsdata !== 32'h0) begin bad++; $display("FAIL rst_blocks_wr got=%h exp=%h", bus.rsdata, 32'h0); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.rsdata !== 32'h0) begin bad++; $display("FAIL post_rst_r5 got=%h exp=%h", bus.rsdata, 32'h0); end
    endtask

    task automatic test_mux;
        logic [1:0]  sel [4];
        logic [31:0] exp [4];
        sel = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp = '{32'h1111_1111, 32'h2222_2222, 32'h0040_0008, 32'h0000_0001};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.aluout   = 32'h1111_1111;
            bus.dmdata   = 32'h2222_2222;
            bus.pcnext   = 32'h0040_0008;
            bus.negative = 1'b1;
            bus.regwr    = 1'b1;
            bus.regdst   = 5'd3;
            bus.memtoreg = sel[k];
            bus.rs       = 5'd0;
            #1;
            total++; if (bus.wbdata !== exp[k]) begin bad++; $display("FAIL mux_wbdata sel=%b got=%h exp=%h", sel[k], bus.wbdata, exp[k]); end
            @(posedge clk);
            #1;
            bus.regwr = 1'b0;
            bus.rs    = 5'd3;
            #1;
            total++; if (bus.rsdata !== exp[k]) begin bad++; $display("FAIL mux_r3 sel=%b got=%h exp=%h", sel[k], bus.rsdata, exp[k]); end
        end
    endtask

    task automatic test_r0;
        @(negedge clk);
        bus.regwr    = 1'b1;
        bus.regdst   = 5'd0;
        bus.memtoreg = WB_ALU;
        bus.aluout   = 32'hDEAD_BEEF;
        bus.rs       = 5'd0;
        bus.rt       = 5'd0;
        #1;
        total++; if (bus.wbvalid !== 1'b0) begin bad++; $display("FAIL r0_wbvalid got=%b exp=0", bus.wbvalid); end
        total++; if (bus.rsdata !== 32'h0) begin bad++; $display("FAIL r0_same_cycle got=%h exp=%h", bus.rsdata, 32'h0); end
        total++; if (bus.wbdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL r0_wbdata got=%h exp=%h", bus.wbdata, 32'hDEAD_BEEF); end
        @(posedge clk);
        #1;
        bus.regwr = 1'b0;
        #1;
        total++; if (bus.rtdata !== 32'h0) begin bad++; $display("FAIL r0_after got=%h exp=%h", bus.rtdata, 32'h0); end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        bus.regwr    = 1'b1;
        bus.regdst   = 5'd7;
        bus.memtoreg = WB_ALU;
        bus.aluout   = 32'hCAFE_F00D;
        bus.rs       = 5'd7;
        bus.rt       = 5'd7;
        #1;
        total++; if (bus.wbvalid !== 1'b1) begin bad++; $display("FAIL byp_wbvalid got=%b exp=1", bus.wbvalid); end
        total++; if (bus.rsdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL byp_rs got=%h exp=%h", bus.rsdata, 32'hCAFE_F00D); end
        total++; if (bus.rtdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL byp_rt got=%h exp=%h", bus.rtdata, 32'hCAFE_F00D); end
        @(posedge clk);
        #1;
        bus.regwr  = 1'b0;
        bus.aluout = 32'h0;
        #1;
        total++; if (bus.rsdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL byp_stored got=%h exp=%h", bus.rsdata, 32'hCAFE_F00D); end
    endtask

    task automatic test_write_disabled;
        wr(5'd9, 32'hA5A5_A5A5);
        @(negedge clk);
        bus.regwr    = 1'b0;
        bus.regdst   = 5'd9;
        bus.memtoreg = WB_ALU;
        bus.aluout   = 32'h1234_5678;
        bus.rs       = 5'd9;
        #1;
        total++; if (bus.rsdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wrdis_now got=%h exp=%h", bus.rsdata, 32'hA5A5_A5A5); end
        total++; if (bus.wbdata !== 32'h1234_5678) begin bad++; $display("FAIL wrdis_wbdata got=%h exp=%h", bus.wbdata, 32'h1234_5678); end
        total++; if (bus.wbvalid !== 1'b0) begin bad++; $display("FAIL wrdis_wbvalid got=%b exp=0", bus.wbvalid); end
        @(posedge clk);
        #1;
        total++; if (bus.rsdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wrdis_after got=%h exp=%h", bus.rsdata, 32'hA5A5_A5A5); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.regwr    = 1'b1;
        bus.regdst   = 5'd4;
        bus.memtoreg = WB_ALU;
        bus.aluout   = 32'h1;
        bus.rs       = 5'd0;
        @(posedge clk);
        #1;
        bus.regwr = 1'b0;
        bus.rs    = 5'd4;
        #1;
        total++; if (bus.rsdata !== 32'h1) begin bad++; $display("FAIL b2b_first got=%h exp=%h", bus.rsdata, 32'h1); end
        bus.aluout = 32'h2;
        bus.regwr  = 1'b1;
        #1;
        total++; if (bus.rsdata !== 32'h2) begin bad++; $display("FAIL b2b_bypass got=%h exp=%h", bus.rsdata, 32'h2); end
        @(posedge clk);
        #1;
        bus.regwr = 1'b0;
        #1;
        total++; if (bus.rsdata !== 32'h2) begin bad++; $display("FAIL b2b_final got=%h exp=%h", bus.rsdata, 32'h2); end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.memtoreg = WB_ALU;
        bus.regwr    = 1'b0;
        bus.regdst   = 5'd0;
        bus.aluout   = 32'h0;
        bus.dmdata   = 32'h0;
        bus.pcnext   = 32'h0;
        bus.negative = 1'b0;
        bus.rs       = 5'd0;
        bus.rt       = 5'd0;

        test_reset_init();
        test_reset();
        test_mux();
        test_r0();
        test_bypass();
        test_write_disabled();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
